// File: rtl/rx_decoder_fsm.sv
// ---------------------------------------------------------------------------
// rx_decoder_fsm
//
// Receive-side state machine placed between a 64b/66b block decoder and the
// MAC. Decoded blocks are checked for legal ordering (idle/control, start,
// data, terminate) using a one-block lookahead. Illegal sequences are replaced
// by the error block, and loss of block lock or high BER forces the local
// fault block. Errored blocks are counted in a saturating counter.
//
// Parameters
//   LEN_RX_DATA  CGMII data width (byte 0 in the MSBs)
//   LEN_RX_CTRL  CGMII control width (byte 0 in the MSB)
//   LEN_ERR_CNT  errored-block counter width
//
// Ports
//   i_clock       single clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_enable      one decoded block per high cycle
//   i_rx_type     decoder block type, one-hot {D,S,C,T}
//   i_rx_data     decoded CGMII data
//   i_rx_ctrl     decoded CGMII control
//   i_block_lock  block-lock status (0 = unlocked)
//   i_hi_ber      high-BER status (1 = high BER)
//   i_clear_cnt   synchronous clear of the error counter
//   o_rx_data     registered CGMII data to the MAC
//   o_rx_ctrl     registered CGMII control to the MAC
//   o_valid       one-cycle strobe after each enabled output update
//   o_state       current state (INIT=0, C=1, D=2, T=3, E=4)
//   o_err_cnt     saturating count of blocks decided as RX_E
// ---------------------------------------------------------------------------
module rx_decoder_fsm #(
    parameter int unsigned LEN_RX_DATA = 64,
    parameter int unsigned LEN_RX_CTRL = 8,
    parameter int unsigned LEN_ERR_CNT = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [3:0]             i_rx_type,
    input  logic [LEN_RX_DATA-1:0] i_rx_data,
    input  logic [LEN_RX_CTRL-1:0] i_rx_ctrl,
    input  logic                   i_block_lock,
    input  logic                   i_hi_ber,
    input  logic                   i_clear_cnt,
    output logic [LEN_RX_DATA-1:0] o_rx_data,
    output logic [LEN_RX_CTRL-1:0] o_rx_ctrl,
    output logic                   o_valid,
    output logic [2:0]             o_state,
    output logic [LEN_ERR_CNT-1:0] o_err_cnt
);

    // Local fault ordered set and error block, as seen by the MAC.
    localparam logic [LEN_RX_DATA-1:0] LBLOCK_DATA = LEN_RX_DATA'(64'h9C00_0001_0000_0000);
    localparam logic [LEN_RX_CTRL-1:0] LBLOCK_CTRL = {1'b1, {(LEN_RX_CTRL-1){1'b0}}};
    localparam logic [LEN_RX_DATA-1:0] EBLOCK_DATA = {(LEN_RX_DATA/8){8'hFE}};
    localparam logic [LEN_RX_CTRL-1:0] EBLOCK_CTRL = '1;

    typedef enum logic [2:0] {
        RX_INIT = 3'd0,
        RX_C    = 3'd1,
        RX_D    = 3'd2,
        RX_T    = 3'd3,
        RX_E    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_D,
        CL_S,
        CL_C,
        CL_T,
        CL_E
    } class_t;

    // Anything that is not exactly one-hot is an error class.
    function automatic class_t classify(input logic [3:0] rx_type);
        class_t c;
        case (rx_type)
            4'b1000: c = CL_D;
            4'b0100: c = CL_S;
            4'b0010: c = CL_C;
            4'b0001: c = CL_T;
            default: c = CL_E;
        endcase
        return c;
    endfunction

    state_t                   state;
    state_t                   next_state;
    logic                     primed;
    logic [3:0]               cur_type;
    logic [LEN_RX_DATA-1:0]   cur_data;
    logic [LEN_RX_CTRL-1:0]   cur_ctrl;
    class_t                   cur_cls;
    class_t                   nxt_cls;
    logic                     link_bad;
    logic                     decide;
    logic                     err_inc;

    assign cur_cls  = classify(cur_type);
    assign nxt_cls  = classify(i_rx_type);
    assign link_bad = !i_block_lock || i_hi_ber;
    // A decision is made only once the lookahead register holds a real block.
    assign decide   = i_enable && primed;
    assign err_inc  = decide && (next_state == RX_E);

    // Terminate is only accepted when the block after it can legally follow
    // an end of frame (start or control).
    always_comb begin
        next_state = RX_E;
        if (link_bad) begin
            next_state = RX_INIT;
        end else begin
            case (state)
                RX_INIT, RX_C, RX_T: begin
                    if (cur_cls == CL_C)      next_state = RX_C;
                    else if (cur_cls == CL_S) next_state = RX_D;
                end
                RX_D: begin
                    if (cur_cls == CL_D)
                        next_state = RX_D;
                    else if (cur_cls == CL_T && (nxt_cls == CL_S || nxt_cls == CL_C))
                        next_state = RX_T;
                end
                RX_E: begin
                    if (cur_cls == CL_C)
                        next_state = RX_C;
                    else if (cur_cls == CL_D)
                        next_state = RX_D;
                    else if (cur_cls == CL_T && (nxt_cls == CL_S || nxt_cls == CL_C))
                        next_state = RX_T;
                end
                default: next_state = RX_E;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= RX_INIT;
            primed    <= 1'b0;
            cur_type  <= '0;
            cur_data  <= '0;
            cur_ctrl  <= '0;
            o_rx_data <= LBLOCK_DATA;
            o_rx_ctrl <= LBLOCK_CTRL;
            o_valid   <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_valid <= 1'b0;

            if (i_enable) begin
                cur_type <= i_rx_type;
                cur_data <= i_rx_data;
                cur_ctrl <= i_rx_ctrl;
                primed   <= 1'b1;
            end

            if (decide) begin
                state   <= next_state;
                o_valid <= 1'b1;
                case (next_state)
                    RX_INIT: begin
                        o_rx_data <= LBLOCK_DATA;
                        o_rx_ctrl <= LBLOCK_CTRL;
                    end
                    RX_E: begin
                        o_rx_data <= EBLOCK_DATA;
                        o_rx_ctrl <= EBLOCK_CTRL;
                    end
                    default: begin
                        o_rx_data <= cur_data;
                        o_rx_ctrl <= cur_ctrl;
                    end
                endcase
            end

            // Clear wins over the old value but still counts a coincident error.
            if (i_clear_cnt) begin
                o_err_cnt <= err_inc ? LEN_ERR_CNT'(1) : '0;
            end else if (err_inc && (o_err_cnt != '1)) begin
                o_err_cnt <= o_err_cnt + LEN_ERR_CNT'(1);
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_rx_decoder_fsm.sv
// ---------------------------------------------------------------------------
// tb_rx_decoder_fsm
//
// Directed bench for rx_decoder_fsm with a 4-bit error counter. A table of
// input blocks with hand-computed expected outputs covers normal framing,
// bad terminate, invalid types, lock loss and high BER; short hand-written
// sequences cover counter saturation, clear-with-error and async reset.
// ---------------------------------------------------------------------------
module tb_rx_decoder_fsm;

    localparam logic [3:0] TD = 4'b1000;
    localparam logic [3:0] TS = 4'b0100;
    localparam logic [3:0] TC = 4'b0010;
    localparam logic [3:0] TT = 4'b0001;
    localparam logic [3:0] TX = 4'b0000;

    localparam logic [63:0] LB = 64'h9C00_0001_0000_0000;
    localparam logic [63:0] EB = 64'hFEFE_FEFE_FEFE_FEFE;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  typ;
    logic [63:0] din;
    logic [7:0]  cin;
    logic        lock;
    logic        ber;
    logic        clr;
    logic [63:0] dout;
    logic [7:0]  cout;
    logic        valid;
    logic [2:0]  state;
    logic [3:0]  cnt;

    int unsigned n_vec;
    int unsigned n_err;

    rx_decoder_fsm #(
        .LEN_RX_DATA(64),
        .LEN_RX_CTRL(8),
        .LEN_ERR_CNT(4)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_enable     (en),
        .i_rx_type    (typ),
        .i_rx_data    (din),
        .i_rx_ctrl    (cin),
        .i_block_lock (lock),
        .i_hi_ber     (ber),
        .i_clear_cnt  (clr),
        .o_rx_data    (dout),
        .o_rx_ctrl    (cout),
        .o_valid      (valid),
        .o_state      (state),
        .o_err_cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  typ;
        logic [7:0]  byt;
        logic [7:0]  ctrl;
        logic        lock;
        logic        ber;
        logic        clr;
        logic [63:0] edata;
        logic [7:0]  ectrl;
        logic        evalid;
        logic [2:0]  estate;
        logic [3:0]  ecnt;
    } vec_t;

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic vec_t mk(input logic e, input logic [3:0] t, input logic [7:0] b,
                                input logic [7:0] c, input logic lk, input logic hb,
                                input logic cl, input logic [63:0] ed, input logic [7:0] ec,
                                input logic ev, input logic [2:0] es, input logic [3:0] en_cnt);
        vec_t v;
        v.en = e; v.typ = t; v.byt = b; v.ctrl = c; v.lock = lk; v.ber = hb; v.clr = cl;
        v.edata = ed; v.ectrl = ec; v.evalid = ev; v.estate = es; v.ecnt = en_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] ed, input logic [7:0] ec,
                         input logic ev, input logic [2:0] es, input logic [3:0] ecn);
        n_vec++;
        if (dout !== ed || cout !== ec || valid !== ev || state !== es || cnt !== ecn) begin
            n_err++;
            $display("FAIL %s: got data=%h ctrl=%h valid=%b state=%0d cnt=%0d, want data=%h ctrl=%h valid=%b state=%0d cnt=%0d",
                     name, dout, cout, valid, state, cnt, ed, ec, ev, es, ecn);
        end
    endtask

    task automatic apply(input logic e, input logic [3:0] t, input logic [7:0] b,
                         input logic [7:0] c, input logic lk, input logic hb, input logic cl);
        @(negedge clk);
        en = e; typ = t; din = rep(b); cin = c; lock = lk; ber = hb; clr = cl;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[27];

    initial begin
        n_vec = 0;
        n_err = 0;

        //           en typ byte ctrl lk hb cl  exp data   ctrl   v  st cnt
        tbl[0]  = mk(1, TC, 8'h11, 8'hFF, 1, 0, 0, LB,        8'h80, 0, 0, 0);
        tbl[1]  = mk(1, TS, 8'h22, 8'h80, 1, 0, 0, rep(8'h11), 8'hFF, 1, 1, 0);
        tbl[2]  = mk(1, TD, 8'h33, 8'h00, 1, 0, 0, rep(8'h22), 8'h80, 1, 2, 0);
        tbl[3]  = mk(1, TD, 8'h44, 8'h00, 1, 0, 0, rep(8'h33), 8'h00, 1, 2, 0);
        tbl[4]  = mk(1, TT, 8'h55, 8'h0F, 1, 0, 0, rep(8'h44), 8'h00, 1, 2, 0);
        tbl[5]  = mk(1, TC, 8'h66, 8'hFF, 1, 0, 0, rep(8'h55), 8'h0F, 1, 3, 0);
        tbl[6]  = mk(0, TD, 8'h77, 8'h00, 1, 0, 0, rep(8'h55), 8'h0F, 0, 3, 0);
        tbl[7]  = mk(1, TC, 8'h88, 8'hFF, 1, 0, 0, rep(8'h66), 8'hFF, 1, 1, 0);
        tbl[8]  = mk(1, TS, 8'h99, 8'h80, 1, 0, 0, rep(8'h88), 8'hFF, 1, 1, 0);
        tbl[9]  = mk(1, TD, 8'hAA, 8'h00, 1, 0, 0, rep(8'h99), 8'h80, 1, 2, 0);
        tbl[10] = mk(1, TT, 8'hBB, 8'h0F, 1, 0, 0, rep(8'hAA), 8'h00, 1, 2, 0);
        tbl[11] = mk(1, TD, 8'hCC, 8'h00, 1, 0, 0, EB,        8'hFF, 1, 4, 1);
        tbl[12] = mk(1, TT, 8'hDD, 8'h0F, 1, 0, 0, rep(8'hCC), 8'h00, 1, 2, 1);
        tbl[13] = mk(1, TC, 8'hEE, 8'hFF, 1, 0, 0, rep(8'hDD), 8'h0F, 1, 3, 1);
        tbl[14] = mk(1, TC, 8'h12, 8'hFF, 1, 0, 0, rep(8'hEE), 8'hFF, 1, 1, 1);
        tbl[15] = mk(1, TX, 8'h13, 8'h00, 1, 0, 0, rep(8'h12), 8'hFF, 1, 1, 1);
        tbl[16] = mk(1, TC, 8'h14, 8'hFF, 1, 0, 0, EB,        8'hFF, 1, 4, 2);
        tbl[17] = mk(1, TC, 8'h15, 8'hFF, 1, 0, 0, rep(8'h14), 8'hFF, 1, 1, 2);
        tbl[18] = mk(1, 4'b0110, 8'h16, 8'h00, 1, 0, 0, rep(8'h15), 8'hFF, 1, 1, 2);
        tbl[19] = mk(1, TC, 8'h17, 8'hFF, 1, 0, 0, EB,        8'hFF, 1, 4, 3);
        tbl[20] = mk(1, TC, 8'h18, 8'hFF, 1, 0, 0, rep(8'h17), 8'hFF, 1, 1, 3);
        tbl[21] = mk(1, TS, 8'h19, 8'h80, 1, 0, 0, rep(8'h18), 8'hFF, 1, 1, 3);
        tbl[22] = mk(1, TC, 8'h1A, 8'hFF, 0, 0, 0, LB,        8'h80, 1, 0, 3);
        tbl[23] = mk(1, TC, 8'h1B, 8'hFF, 1, 0, 0, rep(8'h1A), 8'hFF, 1, 1, 3);
        tbl[24] = mk(1, TC, 8'h1C, 8'hFF, 1, 1, 0, LB,        8'h80, 1, 0, 3);
        tbl[25] = mk(1, TC, 8'h1D, 8'hFF, 1, 0, 0, rep(8'h1C), 8'hFF, 1, 1, 3);
        tbl[26] = mk(1, TC, 8'h1E, 8'hFF, 1, 0, 1, rep(8'h1D), 8'hFF, 1, 1, 0);

        rst_n = 1'b0; en = 1'b0; typ = TC; din = '0; cin = '0;
        lock = 1'b1; ber = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", LB, 8'h80, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply(tbl[i].en, tbl[i].typ, tbl[i].byt, tbl[i].ctrl, tbl[i].lock, tbl[i].ber, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].edata, tbl[i].ectrl, tbl[i].evalid,
                  tbl[i].estate, tbl[i].ecnt);
        end

        // Saturation: first E-type block only decides the preceding C block.
        for (int i = 0; i <= 20; i++) begin
            apply(1, TX, 8'h40 + 8'(i), 8'h00, 1, 0, 0);
            if (i == 0)
                check("sat0", rep(8'h1E), 8'hFF, 1'b1, 3'd1, 4'd0);
            else
                check($sformatf("sat%0d", i), EB, 8'hFF, 1'b1, 3'd4, (i > 15) ? 4'd15 : 4'(i));
        end

        apply(1, TX, 8'h4F, 8'h00, 1, 0, 1);
        check("clr_with_err", EB, 8'hFF, 1'b1, 3'd4, 4'd1);

        apply(1, TC, 8'h50, 8'hFF, 1, 0, 0);
        check("after_clr", EB, 8'hFF, 1'b1, 3'd4, 4'd2);
        apply(1, TS, 8'h51, 8'h80, 1, 0, 0);
        check("e_to_c", rep(8'h50), 8'hFF, 1'b1, 3'd1, 4'd2);
        apply(1, TD, 8'h52, 8'h00, 1, 0, 0);
        check("c_to_d", rep(8'h51), 8'h80, 1'b1, 3'd2, 4'd2);

        // Async reset between edges, checked before any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", LB, 8'h80, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        apply(1, TC, 8'h60, 8'hFF, 1, 0, 0);
        check("reprime", LB, 8'h80, 1'b0, 3'd0, 4'd0);
        apply(1, TS, 8'h61, 8'h80, 1, 0, 0);
        check("post_rst", rep(8'h60), 8'hFF, 1'b1, 3'd1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
